// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory / write-back pipeline stage. Takes the registered EX/MEM bundle,
//   drives a variable-latency data memory over a req/ack handshake, stalls
//   the upstream pipeline while an access is outstanding, and registers the
//   selected write-back result for the register file.
//
// Parameters
//   DBITS            data / address / register-index width
//
// Ports
//   clk, reset_n     clock (posedge) and asynchronous active-low reset
//   memtoReg_m       load: write-back data comes from memory
//   memWrite_m       store (wins over memtoReg_m when both are set)
//   jal_m            write-back data is incrementedPC_m
//   regWrite_m       instruction writes the register file
//   incrementedPC_m  PC+4 of the instruction
//   dstReg_m         destination register index
//   aluOut_m         ALU result / memory address
//   dataFwdOut2_m    store data
//   dmem_req/we/addr/wdata   memory request (we/addr/wdata valid with req)
//   dmem_ack/rdata   memory completion and read data
//   stall            upstream must hold EX/MEM and earlier stages
//   wb_en/dst/data   registered register-file write port
//
// Optional feature (macro MEM_WB_FWD_EN)
//   When defined, adds fwd_valid / fwd_dst / fwd_data: combinational copies
//   of the value about to be registered into wb_*, for the EX forwarding mux.
//   fwd_valid is forced low while stalling or in reset.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             memtoReg_m,
    input  logic             memWrite_m,
    input  logic             jal_m,
    input  logic             regWrite_m,
    input  logic [DBITS-1:0] incrementedPC_m,
    input  logic [DBITS-1:0] dstReg_m,
    input  logic [DBITS-1:0] aluOut_m,
    input  logic [DBITS-1:0] dataFwdOut2_m,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DBITS-1:0] dmem_addr,
    output logic [DBITS-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DBITS-1:0] dmem_rdata,
    output logic             stall,
    output logic             wb_en,
    output logic [DBITS-1:0] wb_dst,
    output logic [DBITS-1:0] wb_data
`ifdef MEM_WB_FWD_EN
    ,
    output logic             fwd_valid,
    output logic [DBITS-1:0] fwd_dst,
    output logic [DBITS-1:0] fwd_data
`endif
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;

    // Latched copy of the request held for the whole WAIT period
    logic             we_q, we_d;
    logic             load_q, load_d;
    logic             jal_q, jal_d;
    logic             regwr_q, regwr_d;
    logic [DBITS-1:0] addr_q, addr_d;
    logic [DBITS-1:0] wdata_q, wdata_d;
    logic [DBITS-1:0] dst_q, dst_d;
    logic [DBITS-1:0] pc_q, pc_d;

    logic             wb_en_q, wb_en_d;
    logic [DBITS-1:0] wb_dst_q, wb_dst_d;
    logic [DBITS-1:0] wb_data_q, wb_data_d;

    logic             req_c;
    logic             stall_c;
    logic             mem_op;
    logic             is_load;
    logic [DBITS-1:0] nonmem_data;

    assign mem_op      = memtoReg_m | memWrite_m;
    // memWrite has priority: a combined memtoReg+memWrite is a store
    assign is_load     = memtoReg_m & ~memWrite_m;
    assign nonmem_data = jal_m ? incrementedPC_m : aluOut_m;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        load_d     = load_q;
        jal_d      = jal_q;
        regwr_d    = regwr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        pc_d       = pc_q;
        wb_en_d    = wb_en_q;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = aluOut_m;
        dmem_wdata = dataFwdOut2_m;

        case (state_q)
            S_IDLE: begin
                req_c      = mem_op;
                dmem_we    = memWrite_m;
                dmem_addr  = aluOut_m;
                dmem_wdata = dataFwdOut2_m;
                // No memory op, or zero-wait completion: write back directly.
                // A load only reaches here with ack set.
                if (!mem_op || dmem_ack) begin
                    wb_en_d   = regWrite_m;
                    wb_dst_d  = dstReg_m;
                    wb_data_d = is_load ? dmem_rdata : nonmem_data;
                end else begin
                    stall_c = 1'b1;
                    we_d    = memWrite_m;
                    load_d  = is_load;
                    jal_d   = jal_m;
                    regwr_d = regWrite_m;
                    addr_d  = aluOut_m;
                    wdata_d = dataFwdOut2_m;
                    dst_d   = dstReg_m;
                    pc_d    = incrementedPC_m;
                    wb_en_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Inputs are ignored here; the request comes from the latches
                req_c      = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_ack) begin
                    wb_en_d   = regwr_q;
                    wb_dst_d  = dst_q;
                    wb_data_d = load_q ? dmem_rdata : (jal_q ? pc_q : addr_q);
                    state_d   = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    wb_en_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset must drop the request and stall immediately, even mid-access
    assign dmem_req = reset_n & req_c;
    assign stall    = reset_n & stall_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            jal_q     <= 1'b0;
            regwr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dst_q     <= '0;
            pc_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            load_q    <= load_d;
            jal_q     <= jal_d;
            regwr_q   <= regwr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dst_q     <= dst_d;
            pc_q      <= pc_d;
            wb_en_q   <= wb_en_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_dst  = wb_dst_q;
    assign wb_data = wb_data_q;

`ifdef MEM_WB_FWD_EN
    assign fwd_valid = reset_n & ~stall_c & wb_en_d;
    assign fwd_dst   = wb_dst_d;
    assign fwd_data  = wb_data_d;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int DBITS = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             memtoReg_m, memWrite_m, jal_m, regWrite_m;
    logic [DBITS-1:0] incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m;
    logic             dmem_req, dmem_we, dmem_ack, stall, wb_en;
    logic [DBITS-1:0] dmem_addr, dmem_wdata, dmem_rdata, wb_dst, wb_data;
`ifdef MEM_WB_FWD_EN
    logic             fwd_valid;
    logic [DBITS-1:0] fwd_dst, fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state: last registered write-back destination/data
    logic [DBITS-1:0] m_dst, m_data;

    typedef struct {
        logic             mtr, mw, jal, rw;
        logic [DBITS-1:0] pc, dst, alu, wd, rd;
        int               waits;
    } txn_t;

    mem_wb_stage #(.DBITS(DBITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .memtoReg_m(memtoReg_m), .memWrite_m(memWrite_m), .jal_m(jal_m),
        .regWrite_m(regWrite_m), .incrementedPC_m(incrementedPC_m),
        .dstReg_m(dstReg_m), .aluOut_m(aluOut_m), .dataFwdOut2_m(dataFwdOut2_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data)
`ifdef MEM_WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_rand();
        memtoReg_m      = 1'($urandom);
        memWrite_m      = 1'($urandom);
        jal_m           = 1'($urandom);
        regWrite_m      = 1'($urandom);
        incrementedPC_m = $urandom;
        dstReg_m        = $urandom;
        aluOut_m        = $urandom;
        dataFwdOut2_m   = $urandom;
    endtask

    // Plays one instruction: presented at cycle 0, memory acks after t.waits
    // extra cycles. Non-memory ops take exactly one cycle.
    // Entered and left at posedge+1.
    task automatic run_txn(input txn_t t);
        logic             mem, ld;
        int               n;
        logic [DBITS-1:0] res;
        mem = t.mtr | t.mw;
        ld  = t.mtr & ~t.mw;
        n   = mem ? t.waits : 0;
        res = ld ? t.rd : (t.jal ? t.pc : t.alu);
        for (int c = 0; c <= n; c++) begin
            if (c == 0) begin
                memtoReg_m = t.mtr; memWrite_m = t.mw; jal_m = t.jal; regWrite_m = t.rw;
                incrementedPC_m = t.pc; dstReg_m = t.dst; aluOut_m = t.alu; dataFwdOut2_m = t.wd;
            end else begin
                drive_rand();   // inputs during WAIT must not matter
            end
            dmem_ack   = mem ? (c == n) : 1'($urandom);
            dmem_rdata = (c == n) ? t.rd : $urandom;
            #2;
            chk("req", {31'd0, dmem_req}, {31'd0, mem});
            chk("stall", {31'd0, stall}, {31'd0, (mem && c < n)});
            if (mem) begin
                chk("we", {31'd0, dmem_we}, {31'd0, t.mw});
                chk("addr", dmem_addr, t.alu);
                chk("wdata", dmem_wdata, t.wd);
            end
`ifdef MEM_WB_FWD_EN
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, (c == n) && t.rw});
            if (c == n && t.rw) begin
                chk("fwd_dst", fwd_dst, t.dst);
                chk("fwd_data", fwd_data, res);
            end
`endif
            @(posedge clk); #1;
            if (c < n) begin
                chk("wb_en_bubble", {31'd0, wb_en}, 32'd0);
            end else begin
                m_dst  = t.dst;
                m_data = res;
                chk("wb_en", {31'd0, wb_en}, {31'd0, t.rw});
                chk("wb_dst", wb_dst, m_dst);
                chk("wb_data", wb_data, m_data);
            end
        end
    endtask

    function automatic txn_t mk(input logic mtr, mw, jal, rw,
                                input logic [DBITS-1:0] pc, dst, alu, wd, rd,
                                input int waits);
        txn_t t;
        t.mtr = mtr; t.mw = mw; t.jal = jal; t.rw = rw;
        t.pc = pc; t.dst = dst; t.alu = alu; t.wd = wd; t.rd = rd; t.waits = waits;
        return t;
    endfunction

    initial begin
        txn_t t;
        reset_n = 1'b0;
        memtoReg_m = 0; memWrite_m = 0; jal_m = 0; regWrite_m = 0;
        incrementedPC_m = 0; dstReg_m = 0; aluOut_m = 0; dataFwdOut2_m = 0;
        dmem_ack = 0; dmem_rdata = 0;
        m_dst = '0; m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_dst", wb_dst, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_txn(mk(0, 0, 0, 1, 32'h0,  32'd5, 32'h1234, 32'h0,    32'h0,    0)); // ALU
        run_txn(mk(0, 0, 1, 1, 32'h40, 32'd6, 32'h99,   32'h0,    32'h0,    0)); // JAL
        run_txn(mk(1, 0, 0, 1, 32'h4,  32'd3, 32'h100,  32'h0,    32'hCAFE, 0)); // zero-wait load
        run_txn(mk(0, 1, 0, 0, 32'h8,  32'd9, 32'h200,  32'hBEEF, 32'h5555, 3)); // 3-wait store
        run_txn(mk(1, 0, 0, 1, 32'hC,  32'd7, 32'h300,  32'h0,    32'h11,   2)); // back-to-back loads
        run_txn(mk(1, 0, 0, 1, 32'h10, 32'd8, 32'h304,  32'h0,    32'h22,   2));
        run_txn(mk(1, 1, 0, 1, 32'h14, 32'd4, 32'h400,  32'h77,   32'hDEAD, 1)); // load+store = store
        run_txn(mk(0, 0, 0, 0, 32'h18, 32'd2, 32'h500,  32'h0,    32'h0,    0)); // flushed bubble

        // Reset mid-WAIT abandons the access
        memtoReg_m = 1; memWrite_m = 0; jal_m = 0; regWrite_m = 1;
        dstReg_m = 32'd12; aluOut_m = 32'h600; dataFwdOut2_m = 0; incrementedPC_m = 32'h1C;
        dmem_ack = 0;
        @(posedge clk); #1;
        #2;
        chk("wait_req", {31'd0, dmem_req}, 32'd1);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstw_req", {31'd0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_wb_en", {31'd0, wb_en}, 32'd0);
        dmem_ack = 1;
        @(posedge clk); #1;
        chk("rstw_wb_en2", {31'd0, wb_en}, 32'd0);
        m_dst = '0; m_data = '0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Back in IDLE: a zero-wait load is taken straight from the inputs
        run_txn(mk(1, 0, 0, 1, 32'h20, 32'd13, 32'h700, 32'h0, 32'h1357, 0));
        run_txn(mk(0, 0, 0, 1, 32'h24, 32'd14, 32'h777, 32'h0, 32'h0,    0));

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            t.mtr = 1'($urandom); t.mw = 1'($urandom);
            t.jal = 1'($urandom); t.rw = 1'($urandom);
            t.pc = $urandom; t.dst = $urandom_range(0, 31);
            t.alu = $urandom; t.wd = $urandom; t.rd = $urandom;
            t.waits = $urandom_range(0, 3);
            run_txn(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory/write-back stage. Consumes the registered EX/MEM bundle (memtoReg_m, memWrite_m, jal_m, regWrite_m, incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m) and drives a variable-latency data memory over a req/ack handshake. While an access is outstanding it stalls the upstream pipeline. It then registers the selected write-back result for the register file.

Parameters:
DBITS, 32, data/address/register-index bus width (matches the EX/MEM bundle)

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
memtoReg_m  in  1  load: write-back data comes from memory
memWrite_m  in  1  store
jal_m  in  1  write-back data is incrementedPC_m
regWrite_m  in  1  instruction writes the register file
incrementedPC_m  in  DBITS  PC+4 of the instruction
dstReg_m  in  DBITS  destination register index
aluOut_m  in  DBITS  ALU result; memory address for loads and stores
dataFwdOut2_m  in  DBITS  store data
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write, 0 = read; valid only while dmem_req=1
dmem_addr  out  DBITS  memory address
dmem_wdata  out  DBITS  store data
dmem_ack  in  1  memory completes the current request this cycle
dmem_rdata  in  DBITS  read data; valid when dmem_ack=1
stall  out  1  upstream must hold the EX/MEM register and the earlier stages
wb_en  out  1  register-file write enable (registered)
wb_dst  out  DBITS  register-file write index (registered)
wb_data  out  DBITS  register-file write data (registered)

Behaviour:
- Async reset (reset_n=0):
  - FSM enters IDLE.
  - wb_en=0, wb_dst=0, wb_data=0.
  - All latched request fields cleared.
  - dmem_req=0, stall=0.
  - Reset asserted during WAIT abandons the access: dmem_req drops immediately and no write-back occurs.
- FSM states: IDLE, WAIT.
- IDLE, no memory operation (memtoReg_m=0 and memWrite_m=0):
  - dmem_req=0, stall=0.
  - Next edge: wb_en<=regWrite_m, wb_dst<=dstReg_m.
  - wb_data<=incrementedPC_m if jal_m=1, else aluOut_m.
- IDLE, memory operation:
  - Combinational outputs the same cycle: dmem_req=1, dmem_we=memWrite_m, dmem_addr=aluOut_m, dmem_wdata=dataFwdOut2_m.
  - If dmem_ack=1 in that cycle (zero-wait):
    - stall=0, and write-back is registered at the edge.
    - wb_data<=dmem_rdata for a load (memtoReg_m=1, memWrite_m=0).
    - Otherwise wb_data follows the non-memory rule.
    - FSM stays in IDLE.
  - If dmem_ack=0:
    - stall=1.
    - Latch we/addr/wdata/memtoReg/jal/regWrite/dst/incrementedPC.
    - Next edge: FSM goes to WAIT and wb_en<=0 (bubble).
- WAIT:
  - dmem_req=1, with dmem_we/addr/wdata driven from the latched copies, stable every cycle.
  - Cycles with dmem_ack=0: stall=1, wb_en<=0 at each edge.
  - Cycle with dmem_ack=1: stall=0.
    - Next edge: write-back registered from the latched fields, using dmem_rdata for a load. FSM returns to IDLE.
  - Inputs in WAIT are ignored; upstream holds them because stall=1.
- Back-to-back memory ops: the ack cycle in WAIT releases stall. The next instruction is presented the following cycle and re-enters the IDLE memory path with no extra idle cycle.
- memtoReg_m=1 and memWrite_m=1 together: treated as a store (memWrite has priority). dmem_rdata is ignored and wb_data=aluOut_m.
- Store with regWrite_m=0: no write-back, wb_en<=0.
- A flushed instruction arrives with memtoReg/memWrite/regWrite = 0 and passes through as a bubble.
- dmem_ack while dmem_req=0 is ignored.
- Stage latency: non-memory and zero-wait ops take 1 cycle to wb_*; an N-wait access takes N+1 cycles.

Optional Feature:
MEM_WB_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_dst (DBITS) and fwd_data (DBITS).
  - These are combinational copies of the value about to be registered into wb_*.
  - fwd_valid=0 when stall=1 or reset_n=0.
  - Used by the EX-stage forwarding mux.
- Undefined: these ports do not exist; forwarding uses wb_* only, one cycle later.

Test Plan:
- Reset: reset_n=0 mid-simulation with dmem_req=1 in WAIT -> dmem_req=0 and stall=0 immediately; wb_en=0; FSM in IDLE after release.
- ALU op: regWrite=1, dst=5, aluOut=0x1234 -> next edge wb_en=1, wb_dst=5, wb_data=0x1234; dmem_req never asserted.
- JAL: jal=1, regWrite=1, incPC=0x40, aluOut=0x99 -> wb_data=0x40.
- Zero-wait load: memtoReg=1, aluOut=0x100, ack tied high, rdata=0xCAFE -> dmem_req=1, dmem_addr=0x100, stall=0; next edge wb_data=0xCAFE.
- 3-wait store: memWrite=1, aluOut=0x200, dataFwdOut2=0xBEEF, ack on 4th cycle -> stall=1 for 3 cycles, addr/wdata stable, wb_en=0 throughout, FSM back to IDLE after the ack.
- Back-to-back loads, 2 waits each, rdata 0x11 then 0x22 -> two stall bursts with no gap cycle; wb_data sequence 0x11, 0x22; dst indices preserved.
